hwpe_ctrl_uloop_hs: RTL and testbench
=====================================

Name: hwpe_ctrl_uloop_hs

Overview:
Next-generation microcode loop engine for HWPE controllers. It walks a nest of up to NB_LOOPS counters and runs a short per-loop microprogram (MOV/ADD/SUB/NOP) on NB_REG offset registers. After each innermost iteration it emits one token (offsets, indices, updated loop level, last flag) on a valid/ready handshake. It sits between the register file/FSM and the streamer address generators, and adds back-pressure, subtraction, explicit start/done and a last flag.

Parameters:
NB_LOOPS, 4, number of nested loops (>=1)
LENGTH, 16, microcode entries
NB_REG, 4, read/write offset registers
NB_RO_REG, 8, read-only operand inputs
REG_WIDTH, 32, register/operand width
CNT_WIDTH, 16, loop index/range width
(derived) AW = $clog2(NB_REG+NB_RO_REG), PW = $clog2(LENGTH), EW = 2+2*AW

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
test_mode_i  in  1  unused, reserved
clear_i  in  1  synchronous soft clear
start_i  in  1  start a loop nest (pulse)
code_i  in  LENGTH*EW  entry e = {op[1:0], a[AW-1:0], b[AW-1:0]}; op 00 MOV, 01 ADD, 10 SUB, 11 NOP
loop_addr_i  in  NB_LOOPS*PW  first microcode address per loop
loop_nbops_i  in  NB_LOOPS*(PW+1)  ops per loop (0 allowed)
loop_range_i  in  NB_LOOPS*CNT_WIDTH  iterations per loop (0 treated as 1)
ro_reg_i  in  NB_RO_REG*REG_WIDTH  read-only operands
tok_valid_o  out  1  token valid
tok_ready_i  in  1  token consumed
tok_offs_o  out  NB_REG*REG_WIDTH  register values
tok_idx_o  out  NB_LOOPS*CNT_WIDTH  loop indices
tok_loop_o  out  $clog2(NB_LOOPS) (min 1)  highest loop updated for this token
tok_last_o  out  1  final token of nest
busy_o  out  1  nest in progress
done_o  out  1  one-cycle pulse after last handshake

Behaviour:
- Operand space: index < NB_REG selects a register; index NB_REG.. selects ro_reg_i[index-NB_REG]; out-of-range reads return 0.
- Ops: MOV r[a]=opnd[b]; ADD r[a]=opnd[a]+opnd[b]; SUB r[a]=opnd[a]-opnd[b]; modulo 2^REG_WIDTH. Writes to a>=NB_REG are suppressed; NOP never writes.
- FSM IDLE -> EMIT -> (EXEC) -> EMIT ... -> IDLE.
- IDLE: start_i clears registers, indices, loop and op counter, then goes to EMIT. busy_o=1 from the next cycle.
- EMIT: tok_valid_o=1. Outputs are stable while valid & ~ready. On handshake:
  - if tok_last_o: go to IDLE, pulse done_o next cycle.
  - else: L = lowest loop with idx[L] < range[L]-1; idx[L]++, idx[j<L]=0, tok_loop_o<=L; pc=loop_addr[L].
  - then go to EXEC if nbops[L]>0, else straight to EMIT.
- EXEC: one op per cycle, pc++, for nbops[L] cycles, then EMIT.
  - Handshake at cycle t -> next valid at t+nbops[L]+1.
  - First token (all zeros, loop 0) is valid the cycle after start_i.
- tok_last_o = 1 when idx[j]==range[j]-1 for all j.
- Token count = product of ranges.
- pc wraps modulo LENGTH.
- start_i while busy_o is ignored.
- clear_i wins over start_i and the handshake: returns to IDLE, zeroes all state, and suppresses done_o.
- Reset values: all outputs 0; state IDLE.

Optional Feature:
HWPE_CTRL_ULOOP_PRECOMPUTE_EN:
- Defined:
  - A one-entry token buffer decouples the consumer. While a token waits for tok_ready_i, the engine already steps and executes the next token into the engine registers.
  - On handshake, the buffer loads immediately. Back-to-back tokens are possible when the next nbops is 0 or was already computed.
  - Token contents and order are identical to the undefined case.
  - done_o still pulses the cycle after the last handshake.
- Undefined: no buffer; timing exactly as in Behaviour.

Test Plan:
- Setup used by the first three scenarios: NB_LOOPS=2; range={3,2}; ro0=4, ro1=100, ro2=0.
  - loop0: addr0 = ADD r0,ro0; nbops 1.
  - loop1: addr1 = ADD r1,ro1, addr2 = MOV r0,ro2; nbops 2.
- Basic: ready=1 -> 6 tokens:
  - r0 = 0,4,8,0,4,8; r1 = 0,0,0,100,100,100.
  - loop = 0,0,0,1,0,0; last only on token 5.
  - done_o pulses once.
- Back-pressure: same setup, ready low 5 cycles on token 2 -> valid held, r0=8 stable, no extra op executed (without macro), same sequence.
- SUB/suppressed write: SUB r0,ro0 with range {4}, and MOV targeting a RO index -> r0 = 0,-4,-8,-12 (two's complement); RO operand unchanged.
- Zero nbops/range: range={0,0}, nbops 0 -> single token, last=1; done_o the cycle after the handshake.
- Clear mid-run: clear_i during EXEC of token 3 -> valid=0 and busy=0 next cycle, no done_o; a restart reproduces the Basic sequence.
- Async reset mid-EMIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/hwpe_ctrl_uloop_hs.sv
// hwpe_ctrl_uloop_hs: nested-loop microcode engine emitting offset/index tokens over valid/ready.
// Define HWPE_CTRL_ULOOP_PRECOMPUTE_EN to add a one-entry token buffer that lets the engine run ahead.
module hwpe_ctrl_uloop_hs #(
  parameter int NB_LOOPS  = 4,
  parameter int LENGTH    = 16,
  parameter int NB_REG    = 4,
  parameter int NB_RO_REG = 8,
  parameter int REG_WIDTH = 32,
  parameter int CNT_WIDTH = 16,
  parameter int AW = $clog2(NB_REG + NB_RO_REG),
  parameter int PW = $clog2(LENGTH),
  parameter int EW = 2 + 2 * AW,
  parameter int LW = NB_LOOPS > 1 ? $clog2(NB_LOOPS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            test_mode_i,
  input  logic                            clear_i,
  input  logic                            start_i,
  input  logic [LENGTH*EW-1:0]            code_i,
  input  logic [NB_LOOPS*PW-1:0]          loop_addr_i,
  input  logic [NB_LOOPS*(PW+1)-1:0]      loop_nbops_i,
  input  logic [NB_LOOPS*CNT_WIDTH-1:0]   loop_range_i,
  input  logic [NB_RO_REG*REG_WIDTH-1:0]  ro_reg_i,
  output logic                            tok_valid_o,
  input  logic                            tok_ready_i,
  output logic [NB_REG*REG_WIDTH-1:0]     tok_offs_o,
  output logic [NB_LOOPS*CNT_WIDTH-1:0]   tok_idx_o,
  output logic [LW-1:0]                   tok_loop_o,
  output logic                            tok_last_o,
  output logic                            busy_o,
  output logic                            done_o
);
  typedef enum logic [1:0] {IDLE, EMIT, EXEC} state_e;
  state_e state_q;
  logic [REG_WIDTH-1:0] regs_q [NB_REG];
  logic [CNT_WIDTH-1:0] idx_q [NB_LOOPS];
  logic [CNT_WIDTH-1:0] rmax [NB_LOOPS];
  logic [LW-1:0] loop_q, step_l;
  logic [PW-1:0] pc_q, step_pc;
  logic [PW:0] opcnt_q, step_nb;
  logic done_q, done_d, last, adv;
  logic [EW-1:0] ent;
  logic [1:0] op;
  logic [AW-1:0] a, b;
  logic [REG_WIDTH-1:0] va, vb, wr_data;
  logic wr_en;
  logic [NB_REG*REG_WIDTH-1:0] eng_offs;
  logic [NB_LOOPS*CNT_WIDTH-1:0] eng_idx;
  logic unused_test_mode;

  assign unused_test_mode = test_mode_i;

  for (genvar i = 0; i < NB_LOOPS; i++) begin : g_loop
    assign rmax[i] = loop_range_i[i*CNT_WIDTH +: CNT_WIDTH] == '0 ? '0
                   : loop_range_i[i*CNT_WIDTH +: CNT_WIDTH] - CNT_WIDTH'(1);
    assign eng_idx[i*CNT_WIDTH +: CNT_WIDTH] = idx_q[i];
  end
  for (genvar i = 0; i < NB_REG; i++) begin : g_reg
    assign eng_offs[i*REG_WIDTH +: REG_WIDTH] = regs_q[i];
  end

  // registers first, then read-only operands; anything beyond reads as zero
  function automatic logic [REG_WIDTH-1:0] opnd(input logic [AW-1:0] k);
    opnd = '0;
    for (int r = 0; r < NB_REG; r++) opnd = int'(k) == r ? regs_q[r] : opnd;
    for (int r = 0; r < NB_RO_REG; r++)
      opnd = int'(k) == NB_REG + r ? ro_reg_i[r*REG_WIDTH +: REG_WIDTH] : opnd;
  endfunction

  always_comb begin
    last = 1'b1;
    step_l = '0;
    for (int j = NB_LOOPS - 1; j >= 0; j--) begin
      last = last & (idx_q[j] == rmax[j]);
      step_l = idx_q[j] < rmax[j] ? LW'(j) : step_l;
    end
  end

  assign step_pc = loop_addr_i[step_l*PW +: PW];
  assign step_nb = loop_nbops_i[step_l*(PW+1) +: PW+1];

  always_comb begin
    ent = code_i[pc_q*EW +: EW];
    {op, a, b} = ent;
    va = opnd(a);
    vb = opnd(b);
    wr_data = op == 2'b00 ? vb : op == 2'b01 ? va + vb : va - vb;
    wr_en = op != 2'b11 && int'(a) < NB_REG;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      loop_q <= '0;
      pc_q <= '0;
      opcnt_q <= '0;
      done_q <= 1'b0;
      for (int r = 0; r < NB_REG; r++) regs_q[r] <= '0;
      for (int j = 0; j < NB_LOOPS; j++) idx_q[j] <= '0;
    end else if (clear_i || (state_q == IDLE && start_i && !busy_o)) begin
      state_q <= clear_i ? IDLE : EMIT;
      loop_q <= '0;
      pc_q <= '0;
      opcnt_q <= '0;
      done_q <= 1'b0;
      for (int r = 0; r < NB_REG; r++) regs_q[r] <= '0;
      for (int j = 0; j < NB_LOOPS; j++) idx_q[j] <= '0;
    end else begin
      done_q <= done_d;
      if (state_q == EMIT && adv) begin
        if (last) state_q <= IDLE;
        else begin
          for (int j = 0; j < NB_LOOPS; j++)
            idx_q[j] <= LW'(j) < step_l ? '0 : LW'(j) == step_l ? idx_q[j] + CNT_WIDTH'(1) : idx_q[j];
          loop_q <= step_l;
          pc_q <= step_pc;
          opcnt_q <= step_nb;
          state_q <= step_nb == '0 ? EMIT : EXEC;
        end
      end else if (state_q == EXEC) begin
        for (int r = 0; r < NB_REG; r++) if (wr_en && int'(a) == r) regs_q[r] <= wr_data;
        pc_q <= pc_q == PW'(LENGTH - 1) ? '0 : pc_q + PW'(1);
        opcnt_q <= opcnt_q - (PW+1)'(1);
        state_q <= opcnt_q == (PW+1)'(1) ? EMIT : EXEC;
      end
    end
  end

`ifdef HWPE_CTRL_ULOOP_PRECOMPUTE_EN
  logic buf_v_q, buf_last_q;
  logic [LW-1:0] buf_loop_q;
  logic [NB_REG*REG_WIDTH-1:0] buf_offs_q;
  logic [NB_LOOPS*CNT_WIDTH-1:0] buf_idx_q;

  // the engine hands its token over whenever the buffer is empty or draining
  assign adv = state_q == EMIT && (!buf_v_q || tok_ready_i);
  assign done_d = buf_v_q && buf_last_q && tok_ready_i;
  assign busy_o = state_q != IDLE || buf_v_q;
  assign tok_valid_o = buf_v_q;
  assign tok_last_o = buf_v_q && buf_last_q;
  assign tok_offs_o = buf_offs_q;
  assign tok_idx_o = buf_idx_q;
  assign tok_loop_o = buf_loop_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_v_q <= 1'b0;
      buf_last_q <= 1'b0;
      buf_loop_q <= '0;
      buf_offs_q <= '0;
      buf_idx_q <= '0;
    end else if (clear_i || adv) begin
      buf_v_q <= !clear_i;
      buf_last_q <= !clear_i && last;
      buf_loop_q <= clear_i ? '0 : loop_q;
      buf_offs_q <= clear_i ? '0 : eng_offs;
      buf_idx_q <= clear_i ? '0 : eng_idx;
    end else if (tok_ready_i) buf_v_q <= 1'b0;
  end
`else
  assign adv = state_q == EMIT && tok_ready_i;
  assign done_d = adv && last;
  assign busy_o = state_q != IDLE;
  assign tok_valid_o = state_q == EMIT;
  assign tok_last_o = tok_valid_o && last;
  assign tok_offs_o = eng_offs;
  assign tok_idx_o = eng_idx;
  assign tok_loop_o = loop_q;
`endif

  assign done_o = done_q;
endmodule

// File: tb/tb_hwpe_ctrl_uloop_hs.sv
// tb_hwpe_ctrl_uloop_hs: scoreboard bench; a loop-nest model enumerates tokens, a monitor checks them.
module tb_hwpe_ctrl_uloop_hs;
  localparam int NL = 2, LEN = 16, NR = 4, NRO = 8, RW = 32, CW = 16;
  localparam int AW = 4, PW = 4, EW = 10;

  typedef struct packed {
    logic [NR-1:0][RW-1:0] offs;
    logic [NL-1:0][CW-1:0] idx;
    logic                  loop;
    logic                  last;
    int                    gap;
  } tok_t;

  logic clk_i = 0, rst_ni = 0, clear_i = 0, start_i = 0, tok_ready_i = 0;
  logic [LEN-1:0][EW-1:0] code;
  logic [NL-1:0][PW-1:0] addr;
  logic [NL-1:0][PW:0] nbops;
  logic [NL-1:0][CW-1:0] range;
  logic [NRO-1:0][RW-1:0] ro;
  logic tok_valid_o, tok_last_o, busy_o, done_o;
  logic [NR*RW-1:0] tok_offs_o;
  logic [NL*CW-1:0] tok_idx_o;
  logic [0:0] tok_loop_o;

  tok_t sb[$];
  int tests = 0, fails = 0;
  int ncyc = 0, ref_cyc = 0, last_hs = -10, hs_cnt = 0, done_cnt = 0;
  int ready_mode = 3, bp_left = 0;
  bit seen = 0, was_stalled = 0;

  hwpe_ctrl_uloop_hs #(.NB_LOOPS(NL), .LENGTH(LEN), .NB_REG(NR), .NB_RO_REG(NRO),
                       .REG_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(1'b0), .clear_i(clear_i), .start_i(start_i),
    .code_i(code), .loop_addr_i(addr), .loop_nbops_i(nbops), .loop_range_i(range),
    .ro_reg_i(ro), .tok_valid_o(tok_valid_o), .tok_ready_i(tok_ready_i),
    .tok_offs_o(tok_offs_o), .tok_idx_o(tok_idx_o), .tok_loop_o(tok_loop_o),
    .tok_last_o(tok_last_o), .busy_o(busy_o), .done_o(done_o));

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  function automatic logic [RW-1:0] rd(input int k, input logic [NR-1:0][RW-1:0] rg);
    if (k < NR) return rg[k];
    if (k < NR + NRO) return ro[k-NR];
    return '0;
  endfunction

  // token t is the mixed-radix number t over the ranges; its loop is the highest digit that changed
  task automatic push_expected();
    int rr[NL], cur[NL], prev[NL];
    int n = 1;
    logic [NR-1:0][RW-1:0] rg = '0;
    tok_t t;
    for (int j = 0; j < NL; j++) begin
      rr[j] = range[j] == 0 ? 1 : int'(range[j]);
      n *= rr[j];
      prev[j] = 0;
    end
    for (int ti = 0; ti < n; ti++) begin
      int rem = ti, L = 0;
      for (int j = 0; j < NL; j++) begin
        cur[j] = rem % rr[j];
        rem /= rr[j];
        if (ti > 0 && cur[j] != prev[j]) L = j;
      end
      if (ti > 0)
        for (int k = 0; k < int'(nbops[L]); k++) begin
          logic [EW-1:0] e = code[(int'(addr[L]) + k) % LEN];
          logic [1:0] op = e[EW-1 -: 2];
          int a = int'(e[2*AW-1 -: AW]), b = int'(e[AW-1:0]);
          logic [RW-1:0] v = op == 0 ? rd(b, rg) : op == 1 ? rd(a, rg) + rd(b, rg) : rd(a, rg) - rd(b, rg);
          if (op != 3 && a < NR) rg[a] = v;
        end
      t.offs = rg;
      for (int j = 0; j < NL; j++) t.idx[j] = CW'(cur[j]);
      t.loop = 1'(L);
      t.last = ti == n - 1;
      t.gap = ti == 0 ? 1 : int'(nbops[L]) + 1;
      sb.push_back(t);
      prev = cur;
    end
  endtask

  always @(negedge clk_i) begin
    ncyc++;
    if (rst_ni && !clear_i) begin
      if (start_i && !busy_o) ref_cyc = ncyc;
      if (was_stalled) check("valid_held", tok_valid_o, 1);
      was_stalled = tok_valid_o && !tok_ready_i;
      if (tok_valid_o) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_token: got valid token offs=%0h, required no token", tok_offs_o);
        end else begin
          if (!seen) begin
            check("gap", ncyc - ref_cyc, sb[0].gap);
            seen = 1;
          end
          check("tok_offs", tok_offs_o, sb[0].offs);
          check("tok_idx", tok_idx_o, sb[0].idx);
          check("tok_loop", tok_loop_o, sb[0].loop);
          check("tok_last", tok_last_o, sb[0].last);
          if (tok_ready_i) begin
            hs_cnt++;
            ref_cyc = ncyc;
            seen = 0;
            if (sb[0].last) last_hs = ncyc;
            void'(sb.pop_front());
          end
        end
      end
      if (done_o) begin
        done_cnt++;
        check("done_timing", ncyc, last_hs + 1);
      end
    end else was_stalled = 0;
  end

  initial forever begin
    @(posedge clk_i);
    #1;
    if (ready_mode == 0) tok_ready_i = 1;
    else if (ready_mode == 1) tok_ready_i = 1'($urandom_range(0, 1));
    else if (ready_mode == 2 && hs_cnt == 2 && bp_left > 0) begin
      tok_ready_i = 0;
      bp_left--;
    end else tok_ready_i = ready_mode == 2;
  end

  task automatic pulse_start();
    @(posedge clk_i);
    #1 start_i = 1;
    @(posedge clk_i);
    #1 start_i = 0;
  endtask

  task automatic run_nest(input int rmode, input int bp);
    int budget = 0;
    hs_cnt = 0;
    done_cnt = 0;
    ready_mode = rmode;
    bp_left = bp;
    push_expected();
    pulse_start();
    while ((sb.size() != 0 || done_cnt == 0) && budget < 3000) begin
      @(posedge clk_i);
      budget++;
    end
    repeat (3) @(posedge clk_i);
    #1;
    check("sb_drained", sb.size(), 0);
    check("done_once", done_cnt, 1);
    check("idle_after", busy_o, 0);
  endtask

  task automatic setup_basic();
    code = '1;
    code[0] = {2'b01, 4'd0, 4'd4};
    code[1] = {2'b01, 4'd1, 4'd5};
    code[2] = {2'b00, 4'd0, 4'd6};
    addr[0] = 0; addr[1] = 1;
    nbops[0] = 1; nbops[1] = 2;
    range[0] = 3; range[1] = 2;
    ro = '0; ro[0] = 4; ro[1] = 100;
  endtask

  initial begin
    int budget;
    setup_basic();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ctrl", {tok_valid_o, tok_last_o, busy_o, done_o}, 0);
    check("rst_offs", tok_offs_o, 0);
    check("rst_idx", tok_idx_o, 0);
    check("rst_loop", tok_loop_o, 0);
    rst_ni = 1;
    setup_basic();
    run_nest(0, 0);
    setup_basic();
    run_nest(2, 5);
    // SUB on r0, plus a MOV aimed at a read-only index that must not land anywhere
    code = '1;
    code[0] = {2'b10, 4'd0, 4'd4};
    code[1] = {2'b00, 4'd5, 4'd0};
    addr[0] = 0; addr[1] = 2;
    nbops[0] = 2; nbops[1] = 0;
    range[0] = 4; range[1] = 1;
    ro = '0; ro[0] = 4; ro[1] = 7;
    run_nest(0, 0);
    code = '1; addr = '0; nbops = '0; range = '0;
    run_nest(0, 0);
    setup_basic();
    hs_cnt = 0; done_cnt = 0; ready_mode = 0;
    push_expected();
    pulse_start();
    budget = 0;
    do begin @(posedge clk_i); #1; budget++; end while (hs_cnt < 3 && budget < 200);
    check("clr_in_exec", {tok_valid_o, busy_o}, 2'b01);
    clear_i = 1;
    sb.delete();
    seen = 0;
    @(posedge clk_i);
    #1 clear_i = 0;
    check("clr_valid", tok_valid_o, 0);
    check("clr_busy", busy_o, 0);
    repeat (8) @(posedge clk_i);
    check("clr_no_done", done_cnt, 0);
    run_nest(0, 0);
    setup_basic();
    hs_cnt = 0; ready_mode = 0;
    push_expected();
    pulse_start();
    budget = 0;
    do begin @(posedge clk_i); #1; budget++; end while (hs_cnt < 1 && budget < 200);
    ready_mode = 3;
    budget = 0;
    while (!tok_valid_o && budget < 20) begin @(posedge clk_i); #1; budget++; end
    check("ar_before", {tok_valid_o, busy_o}, 2'b11);
    #2 rst_ni = 0;
    #1;
    check("ar_ctrl", {tok_valid_o, tok_last_o, busy_o, done_o}, 0);
    check("ar_offs", tok_offs_o, 0);
    check("ar_idx", tok_idx_o, 0);
    check("ar_loop", tok_loop_o, 0);
    sb.delete();
    seen = 0;
    @(posedge clk_i);
    #1 rst_ni = 1;
    for (int k = 0; k < 20; k++) begin
      for (int e = 0; e < LEN; e++) code[e] = EW'($urandom);
      for (int j = 0; j < NL; j++) begin
        addr[j] = PW'($urandom_range(0, LEN - 1));
        nbops[j] = (PW+1)'($urandom_range(0, 4));
        range[j] = CW'($urandom_range(0, 4));
      end
      for (int r = 0; r < NRO; r++) ro[r] = $urandom;
      run_nest($urandom_range(0, 1), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tokens still expected", sb.size());
    $fatal(1, "timeout");
  end
endmodule
